// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause 22 MDIO master.
package mdio_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_HDR,
      S_TA,
      S_DATA,
      S_END
   } state_e;

   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] ST       = 2'b01;

   localparam int PRE_BITS   = 32;
   localparam int FRAME_BITS = 64;
   localparam int TA_BIT     = PRE_BITS + 14;
   localparam int DATA_BIT   = TA_BIT + 2;

   // Reads leave TA and DATA as ones so the line idles high if ever driven.
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic        wr,
      input logic [4:0]  pa,
      input logic [4:0]  ra,
      input logic [15:0] wd
   );
      build_frame = {{PRE_BITS{1'b1}}, ST,
                     wr ? OP_WRITE : OP_READ,
                     pa, ra,
                     wr ? 2'b10 : 2'b11,
                     wr ? wd : 16'hFFFF};
   endfunction

   function automatic state_e phase_of(input logic [6:0] b);
      if (b < 7'(PRE_BITS)) begin
         return S_PRE;
      end else if (b < 7'(TA_BIT)) begin
         return S_HDR;
      end else if (b < 7'(DATA_BIT)) begin
         return S_TA;
      end else if (b < 7'(FRAME_BITS)) begin
         return S_DATA;
      end
      return S_END;
   endfunction

endpackage

// File: rtl/mdio_tick.sv
// MDC half-period tick generator; counts only while a frame is in flight.
module mdio_tick #(
   parameter int CLK_DIV = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o,
   output logic early_o
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o  = (cnt_q == CW'(CLK_DIV - 1));
   assign early_o = (cnt_q == CW'(CLK_DIV - 2));
   assign cnt_d   = tick_o ? '0 : cnt_q + CW'(1);

   always_ff @(posedge clk) begin
      if (rst || !en_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO master: one read or write frame per accepted command.
module mdio_master
   import mdio_pkg::*;
#(
   parameter int CLK_DIV    = 25,
   parameter int PHY_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [PHY_ADDR_W-1:0] cmd_phyaddr,
   input  logic [PHY_ADDR_W-1:0] cmd_regaddr,
   input  logic [15:0]           cmd_wdata,
   output logic                  rsp_valid,
   output logic [15:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  mdc,
   output logic                  mdio_o,
   output logic                  mdio_oe,
   input  logic                  mdio_i
);

   state_e                state_q;
   logic [6:0]            bit_q;
   logic [6:0]            bit_d;
   logic [FRAME_BITS-1:0] sh_q;
   logic [FRAME_BITS-1:0] frame_d;
   logic                  mdc_q;
   logic                  mdo_q;
   logic                  oe_q;
   logic                  wr_q;
   logic                  err_q;
   logic [15:0]           rd_q;
   logic                  rv_q;
   logic [15:0]           rdata_q;
   logic                  rerr_q;
   logic                  tick;
   logic                  early;

   assign frame_d = build_frame(cmd_write, cmd_phyaddr,
                                cmd_regaddr, cmd_wdata);
   assign bit_d   = bit_q + 7'd1;

   assign busy      = (state_q != S_IDLE);
   assign cmd_ready = !busy && !rst;
   assign rsp_valid = rv_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = rerr_q;
   assign mdc       = mdc_q;
   assign mdio_o    = mdo_q;
   assign mdio_oe   = oe_q;

   mdio_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .en_i    (busy),
      .tick_o  (tick),
      .early_o (early)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         bit_q   <= '0;
         sh_q    <= '0;
         mdc_q   <= 1'b0;
         mdo_q   <= 1'b1;
         oe_q    <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         rd_q    <= '0;
         rv_q    <= 1'b0;
         rdata_q <= '0;
         rerr_q  <= 1'b0;
      end else begin
         rv_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               mdc_q <= 1'b0;
               oe_q  <= 1'b0;
               mdo_q <= 1'b1;
               if (cmd_valid) begin
                  state_q <= S_PRE;
                  bit_q   <= '0;
                  wr_q    <= cmd_write;
                  err_q   <= 1'b0;
                  mdo_q   <= frame_d[FRAME_BITS-1];
                  sh_q    <= {frame_d[FRAME_BITS-2:0], 1'b0};
                  oe_q    <= 1'b1;
               end
            end
            // END keeps MDC low and finishes one cycle early so the
            // IDLE/accept cycle completes the last bit period.
            S_END: begin
               if (tick) begin
                  bit_q <= bit_d;
               end else if (early && bit_q == 7'(FRAME_BITS + 1)) begin
                  state_q <= S_IDLE;
                  rv_q    <= 1'b1;
                  rdata_q <= wr_q ? 16'h0000 : rd_q;
                  rerr_q  <= wr_q ? 1'b0 : err_q;
               end
            end
            default: begin
               if (tick && !mdc_q) begin
                  mdc_q <= 1'b1;
                  if (state_q == S_TA && bit_q[0]) begin
                     err_q <= mdio_i;
                  end
                  if (state_q == S_DATA) begin
                     rd_q <= {rd_q[14:0], mdio_i};
                  end
               end else if (tick) begin
                  mdc_q   <= 1'b0;
                  bit_q   <= bit_d;
                  state_q <= phase_of(bit_d);
                  if (bit_d == 7'(FRAME_BITS)) begin
                     oe_q  <= 1'b0;
                     mdo_q <= 1'b1;
                  end else begin
                     mdo_q <= sh_q[FRAME_BITS-1];
                     sh_q  <= {sh_q[FRAME_BITS-2:0], 1'b0};
                     oe_q  <= wr_q || (bit_d < 7'(TA_BIT));
                  end
               end
            end
         endcase
      end
   end

endmodule
